// File: rtl/spi_sram_ctrl.sv
// rtl/spi_sram_ctrl.sv - single-word SPI mode-0 serial SRAM frame controller
`timescale 1ns/1ps

module spi_sram_ctrl #(
    parameter int         CLK_DIV   = 2,
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [22:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CS_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT    = 3'd2;
    localparam logic [2:0] ST_CS_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [5:0]    bit_q, bit_d;
    logic [63:0]   frame_q, frame_d;
    logic [31:0]   rx_q, rx_d;
    logic          wr_q, wr_d;
    logic          sclk_q, sclk_d;
    logic          cs_n_q, cs_n_d;
    logic          mosi_q, mosi_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic [63:0]   new_frame;

    // Frame captured at acceptance: opcode, zero pad bit, word pointer, data (zero for reads)
    assign new_frame = {req_write ? CMD_WRITE : CMD_READ, 1'b0, req_addr,
                        req_write ? req_wdata : 32'h0};

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign spi_sclk  = sclk_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_mosi  = mosi_q;

    // Next-state: frame sequencing, sclk phase generation, shift in/out
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        frame_d     = frame_q;
        rx_d        = rx_q;
        wr_d        = wr_q;
        sclk_d      = sclk_q;
        cs_n_d      = cs_n_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    frame_d = new_frame;
                    wr_d    = req_write;
                    mosi_d  = new_frame[63];
                    cs_n_d  = 1'b0;
                    div_d   = '0;
                    rx_d    = 32'h0;
                    state_d = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        // Rising sclk: sample miso; only the data half feeds the read word
                        sclk_d = 1'b1;
                        if (bit_q[5]) begin
                            rx_d = {rx_q[30:0], spi_miso};
                        end
                    end else begin
                        // Falling sclk: advance to the next bit (zero after the last one)
                        sclk_d  = 1'b0;
                        frame_d = {frame_q[62:0], 1'b0};
                        mosi_d  = frame_q[62];
                        bit_d   = bit_q + 6'd1;
                        if (bit_q == 6'd63) begin
                            state_d = ST_CS_HOLD;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_CS_HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d       = '0;
                    cs_n_d      = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = wr_q ? 32'h0 : rx_q;
                    state_d     = ST_DONE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops the frame immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bit_q       <= 6'd0;
            frame_q     <= 64'h0;
            rx_q        <= 32'h0;
            wr_q        <= 1'b0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            frame_q     <= frame_d;
            rx_q        <= rx_d;
            wr_q        <= wr_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// tb/tb_spi_sram_ctrl.sv - directed self-checking bench for spi_sram_ctrl
`timescale 1ns/1ps

module tb_spi_sram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          checks = 0;
    int          passed = 0;

    // CLK_DIV = 2 instance
    logic        req_valid, req_ready, req_write;
    logic [22:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        spi_sclk, spi_cs_n, spi_mosi;
    logic        spi_miso = 1'b0;

    // CLK_DIV = 1 instance
    logic        req_valid2, req_ready2, req_write2;
    logic [22:0] req_addr2;
    logic [31:0] req_wdata2;
    logic        rsp_valid2;
    logic [31:0] rsp_rdata2;
    logic        spi_sclk2, spi_cs_n2, spi_mosi2;
    logic        spi_miso2 = 1'b1;

    spi_sram_ctrl #(.CLK_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    spi_sram_ctrl #(.CLK_DIV(1)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write2),
        .req_addr(req_addr2), .req_wdata(req_wdata2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
        .spi_sclk(spi_sclk2), .spi_cs_n(spi_cs_n2), .spi_mosi(spi_mosi2), .spi_miso(spi_miso2)
    );

    // SRAM-side model: capture mosi on sclk rise, present read data on sclk fall
    logic [63:0] cap_frame = 64'h0;
    int          cap_cnt = 0;
    logic [31:0] sram_word = 32'h0;
    logic [63:0] cap_frame2 = 64'h0;
    int          cap_cnt2 = 0;

    always @(posedge spi_sclk or negedge spi_cs_n) begin
        if (spi_sclk) begin
            cap_frame = {cap_frame[62:0], spi_mosi};
            cap_cnt   = cap_cnt + 1;
        end else begin
            cap_frame = 64'h0;
            cap_cnt   = 0;
        end
    end

    always @(negedge spi_sclk) begin
        if (!spi_cs_n && cap_cnt >= 32 && cap_cnt < 64)
            spi_miso = sram_word[63 - cap_cnt];
    end

    always @(posedge spi_sclk2 or negedge spi_cs_n2) begin
        if (spi_sclk2) begin
            cap_frame2 = {cap_frame2[62:0], spi_mosi2};
            cap_cnt2   = cap_cnt2 + 1;
        end else begin
            cap_frame2 = 64'h0;
            cap_cnt2   = 0;
        end
    end

    // One full frame on the CLK_DIV=2 instance; k counts cycles after the accepting edge
    task automatic run_frame(input logic wr, input logic [22:0] addr, input logic [31:0] wdata,
                             output int rsp_k, output int rsp_n, output logic [31:0] rdata,
                             output int bad_sclk);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = 23'($urandom); req_wdata = $urandom;
        rsp_k = -1; rsp_n = 0; rdata = 32'hx; bad_sclk = 0;
        for (int k = 1; k <= 400; k++) begin
            if (k > 1) @(negedge clk);
            if (rsp_valid) begin
                rsp_n++;
                if (rsp_k < 0) begin rsp_k = k; rdata = rsp_rdata; end
            end
            if (spi_cs_n && spi_sclk) bad_sclk++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid = 1'($urandom); req_write = 1'($urandom);
            req_addr = 23'($urandom); req_wdata = $urandom;
            req_valid2 = 1'($urandom); req_write2 = 1'($urandom);
            req_addr2 = 23'($urandom); req_wdata2 = $urandom;
            #1;
            checks++; if (spi_cs_n !== 1'b1) $display("FAIL reset_cs_n got %b want 1", spi_cs_n); else passed++;
            checks++; if (spi_sclk !== 1'b0) $display("FAIL reset_sclk got %b want 0", spi_sclk); else passed++;
            checks++; if (spi_mosi !== 1'b0) $display("FAIL reset_mosi got %b want 0", spi_mosi); else passed++;
            checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passed++;
            checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else passed++;
            checks++; if (spi_cs_n2 !== 1'b1) $display("FAIL reset_cs_n2 got %b want 1", spi_cs_n2); else passed++;
        end
        checks++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); else passed++;
        @(negedge clk);
        req_valid = 1'b0; req_valid2 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int rk, rn, bad;
        logic [31:0] rd;
        run_frame(1'b1, 23'h001234, 32'hDEADBEEF, rk, rn, rd, bad);
        checks++; if (cap_frame !== 64'h02001234_DEADBEEF) $display("FAIL write_frame got %h want 02001234deadbeef", cap_frame); else passed++;
        checks++; if (cap_cnt !== 64) $display("FAIL write_sclk_rises got %0d want 64", cap_cnt); else passed++;
        checks++; if (rk !== 261) $display("FAIL write_rsp_cycle got %0d want 261", rk); else passed++;
        checks++; if (rn !== 1) $display("FAIL write_rsp_count got %0d want 1", rn); else passed++;
        checks++; if (rd !== 32'h0) $display("FAIL write_rdata got %h want 0", rd); else passed++;
        checks++; if (bad !== 0) $display("FAIL write_sclk_idle got %0d want 0", bad); else passed++;
    endtask

    task automatic test_read();
        int rk, rn, bad;
        logic [31:0] rd;
        sram_word = 32'hA5C30F96;
        run_frame(1'b0, 23'h7FFFFF, 32'hFFFF0000, rk, rn, rd, bad);
        checks++; if (cap_frame[63:32] !== 32'h037FFFFF) $display("FAIL read_header got %h want 037fffff", cap_frame[63:32]); else passed++;
        checks++; if (cap_frame[31:0] !== 32'h0) $display("FAIL read_dummy_data got %h want 0", cap_frame[31:0]); else passed++;
        checks++; if (rk !== 261) $display("FAIL read_rsp_cycle got %0d want 261", rk); else passed++;
        checks++; if (rd !== 32'hA5C30F96) $display("FAIL read_rdata got %h want a5c30f96", rd); else passed++;
        checks++; if (rsp_rdata !== 32'hA5C30F96) $display("FAIL read_rdata_held got %h want a5c30f96", rsp_rdata); else passed++;
    endtask

    task automatic test_back_to_back();
        int acc[2];
        int n_acc = 0, rn = 0, cons = 0, csn_hi = 0;
        logic prev = 1'b0;
        logic [31:0] last_rd = 32'h0;
        sram_word = 32'h5A0FF0C3;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 23'h000010; req_wdata = 32'h0;
        acc[0] = -1; acc[1] = -1;
        for (int i = 0; i < 700; i++) begin
            if (i > 0) @(negedge clk);
            if (rsp_valid) begin
                rn++;
                if (prev) cons++;
                last_rd = rsp_rdata;
            end
            prev = rsp_valid;
            if (n_acc == 1 && spi_cs_n) csn_hi++;
            if (req_valid && req_ready) begin
                if (n_acc < 2) acc[n_acc] = i;
                n_acc++;
            end else if (n_acc == 2) begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        checks++; if (n_acc !== 2) $display("FAIL b2b_accepts got %0d want 2", n_acc); else passed++;
        checks++; if (acc[1] - acc[0] !== 262) $display("FAIL b2b_spacing got %0d want 262", acc[1] - acc[0]); else passed++;
        checks++; if (csn_hi !== 2) $display("FAIL b2b_cs_gap got %0d want 2", csn_hi); else passed++;
        checks++; if (rn !== 2) $display("FAIL b2b_rsp_count got %0d want 2", rn); else passed++;
        checks++; if (cons !== 0) $display("FAIL b2b_rsp_width got %0d want 0", cons); else passed++;
        checks++; if (last_rd !== 32'h5A0FF0C3) $display("FAIL b2b_rdata got %h want 5a0ff0c3", last_rd); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int rk, rn, bad, stray = 0;
        logic [31:0] rd;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 23'h000777; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 2; k <= 100; k++) @(negedge clk);
        checks++; if (spi_cs_n !== 1'b0) $display("FAIL midrst_pre_cs_n got %b want 0", spi_cs_n); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (spi_cs_n !== 1'b1) $display("FAIL midrst_cs_n got %b want 1", spi_cs_n); else passed++;
        checks++; if (spi_sclk !== 1'b0) $display("FAIL midrst_sclk got %b want 0", spi_sclk); else passed++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (rsp_valid) stray++;
        end
        checks++; if (stray !== 0) $display("FAIL midrst_stray_rsp got %0d want 0", stray); else passed++;
        checks++; if (req_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", req_ready); else passed++;
        run_frame(1'b1, 23'h0055AA, 32'h01234567, rk, rn, rd, bad);
        checks++; if (cap_frame !== 64'h020055AA_01234567) $display("FAIL midrst_next_frame got %h want 020055aa01234567", cap_frame); else passed++;
        checks++; if (rk !== 261) $display("FAIL midrst_next_rsp got %0d want 261", rk); else passed++;
    endtask

    task automatic test_clkdiv1();
        int rk = -1, r1 = -1, r2 = -1;
        logic [31:0] rd = 32'hx;
        logic prev_s = 1'b0;
        @(negedge clk);
        req_valid2 = 1'b1; req_write2 = 1'b0; req_addr2 = 23'h000000; req_wdata2 = 32'h89ABCDEF;
        @(posedge clk);
        @(negedge clk);
        req_valid2 = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (k > 1) @(negedge clk);
            if (rsp_valid2 && rk < 0) begin rk = k; rd = rsp_rdata2; end
            if (spi_sclk2 && !prev_s) begin
                if (r1 < 0) r1 = k;
                else if (r2 < 0) r2 = k;
            end
            prev_s = spi_sclk2;
        end
        checks++; if (rk !== 131) $display("FAIL div1_rsp_cycle got %0d want 131", rk); else passed++;
        checks++; if (rd !== 32'hFFFFFFFF) $display("FAIL div1_rdata got %h want ffffffff", rd); else passed++;
        checks++; if (r2 - r1 !== 2) $display("FAIL div1_sclk_period got %0d want 2", r2 - r1); else passed++;
        checks++; if (r1 !== 3) $display("FAIL div1_first_rise got %0d want 3", r1); else passed++;
        checks++; if (cap_cnt2 !== 64) $display("FAIL div1_sclk_rises got %0d want 64", cap_cnt2); else passed++;
        checks++; if (cap_frame2[63:32] !== 32'h03000000) $display("FAIL div1_header got %h want 03000000", cap_frame2[63:32]); else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_valid2 = 1'b0; req_write2 = 1'b0; req_addr2 = '0; req_wdata2 = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid_frame();
        test_clkdiv1();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
